// File: rtl/debounce_edge_if.sv
// ============================================================================
// Module      : debounce_edge_if
// Description : Signal bundle between a raw level source and the debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface debounce_edge_if;
    logic d;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    // master drives the raw level and observes the cleaned outputs
    modport master (output d, input q, input rise, input fall, input busy);
    modport slave  (input d, output q, output rise, output fall, output busy);
endinterface

`default_nettype wire

// File: rtl/debounce_edge.sv
// ============================================================================
// Module      : debounce_edge
// Description : Two-flop synchroniser plus stability-qualified level filter
//               with registered rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_edge #(
    parameter int   STABLE_CNT = 10,
    parameter int   CNT_W      = 4,
    parameter logic INIT       = 1'b0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    debounce_edge_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_s1;
    logic             r_s2;
    logic             r_q;
    logic             w_q_next;
    logic             r_rise;
    logic             w_rise_next;
    logic             r_fall;
    logic             w_fall_next;
    logic             r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= INIT;
            r_s2    <= INIT;
            r_q     <= INIT;
            r_cnt   <= '0;
            r_state <= IDLE;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_s1    <= bus.d;
            r_s2    <= r_s1;
            r_q     <= w_q_next;
            r_cnt   <= w_cnt_next;
            r_state <= w_state_next;
            r_rise  <= w_rise_next;
            r_fall  <= w_fall_next;
            r_busy  <= (w_state_next == CHECK);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_q_next     = r_q;
        w_rise_next  = 1'b0;
        w_fall_next  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_s2 != r_q) begin
                    w_state_next = CHECK;
                    w_cnt_next   = c_one;
                end else begin
                    w_cnt_next   = '0;
                end
            end
            CHECK: begin
                // any reversion to the current level discards the candidate
                if (r_s2 == r_q) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt < c_last) begin
                    w_cnt_next   = r_cnt + c_one;
                end else begin
                    w_q_next     = r_s2;
                    w_rise_next  = r_s2;
                    w_fall_next  = ~r_s2;
                    w_cnt_next   = '0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign bus.q    = r_q;
    assign bus.rise = r_rise;
    assign bus.fall = r_fall;
    assign bus.busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_debounce_edge.sv
// ============================================================================
// Module      : tb_debounce_edge
// Description : Scoreboard bench for debounce_edge with a run-length model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_edge;

    localparam int   STABLE_CNT = 10;
    localparam int   CNT_W      = 4;
    localparam logic INIT       = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    debounce_edge_if bus();

    debounce_edge #(
        .STABLE_CNT (STABLE_CNT),
        .CNT_W      (CNT_W),
        .INIT       (INIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         tests  = 0;
    int         failed = 0;
    logic [3:0] exp_q[$];
    logic [3:0] m_exp;
    logic [3:0] m_act;
    logic       in_bounce = 1'b0;
    int         bounce_rises = 0;

    // Reference: q flips once the delayed input has disagreed with q on
    // STABLE_CNT consecutive edges; the delay is a two-sample history.
    logic pipe[$];
    logic m_q;
    int   m_run;

    task automatic step(input logic r, input logic dv);
        logic s2_old;
        logic m_rise;
        logic m_fall;
        @(negedge clk);
        rst   = r;
        bus.d = dv;
        @(posedge clk);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (r) begin
            pipe  = '{INIT, INIT};
            m_q   = INIT;
            m_run = 0;
        end else begin
            s2_old = pipe[1];
            pipe.push_front(dv);
            void'(pipe.pop_back());
            if (s2_old != m_q) m_run = m_run + 1;
            else               m_run = 0;
            if (m_run == STABLE_CNT) begin
                m_q    = s2_old;
                m_rise = s2_old;
                m_fall = ~s2_old;
                m_run  = 0;
            end
        end
        exp_q.push_back({m_q, m_rise, m_fall, (m_run != 0)});
    endtask

    task automatic hold(input logic dv, input int n);
        for (int i = 0; i < n; i++) step(1'b0, dv);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
            m_act = {bus.q, bus.rise, bus.fall, bus.busy};
            tests = tests + 1;
            if (m_act !== m_exp) begin
                failed = failed + 1;
                $display("FAIL outputs t=%0t {q,rise,fall,busy} got %b expected %b",
                         $time, m_act, m_exp);
            end
            if (in_bounce && bus.rise) bounce_rises = bounce_rises + 1;
        end
    end

    initial begin
        pipe  = '{INIT, INIT};
        m_q   = INIT;
        m_run = 0;
        bus.d = 1'b1;

        // reset held with d high
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        // clean rise, then clean fall
        hold(1'b1, 20);
        hold(1'b0, 15);
        // glitch shorter than the qualification window
        hold(1'b1, 5);
        hold(1'b0, 12);
        // bounce then settle high: exactly one rise expected
        in_bounce = 1'b1;
        for (int k = 0; k < 5; k++) hold(k[0] ? 1'b0 : 1'b1, 3);
        hold(1'b1, 20);
        in_bounce = 1'b0;
        // fall back low, then reset in the middle of qualifying a rise
        hold(1'b0, 15);
        hold(1'b1, 7);
        step(1'b1, 1'b1);
        hold(1'b1, 15);
        // d changes right at a qualifying edge
        hold(1'b0, STABLE_CNT + 1);
        hold(1'b1, 15);

        // randomized bursts of varying length with occasional resets
        for (int n = 0; n < 250; n++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = (($urandom_range(0, 3) == 0) ? $urandom_range(8, 16)
                                               : $urandom_range(1, 6));
            if ($urandom_range(0, 60) == 0) step(1'b1, lvl);
            hold(lvl, len);
        end

        repeat (3) @(posedge clk);
        #2;
        tests = tests + 1;
        if (exp_q.size() != 0) begin
            failed = failed + 1;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        tests = tests + 1;
        if (bounce_rises != 1) begin
            failed = failed + 1;
            $display("FAIL bounce_rise_count got %0d expected 1", bounce_rises);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
